// File: rtl/csr_stream_packer.sv
// Packs one scalar CSR element per cycle into PARALLELISM-lane output beats.
// Holds at most two complete beats: the output register plus one pending beat in the accumulator.
module csr_stream_packer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PARALLELISM = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [DATA_WIDTH-1:0]                  i_s_data,
  input  logic                                   i_s_valid,
  output logic                                   o_s_ready,
  input  logic                                   i_s_last,
  output logic [PARALLELISM-1:0][DATA_WIDTH-1:0] o_m_data,
  output logic                                   o_m_valid,
  input  logic                                   i_m_ready,
  output logic                                   o_m_last,
  output logic                                   o_m_bytemask,
  output logic                                   o_busy
);

  localparam int unsigned LANE_W = $clog2(PARALLELISM);
  localparam logic [LANE_W-1:0] LastLane = LANE_W'(PARALLELISM - 1);

  typedef logic [PARALLELISM-1:0][DATA_WIDTH-1:0] beat_t;

  beat_t             r_acc, w_acc_nxt;
  logic [LANE_W-1:0] r_lane, w_lane_nxt;
  logic              r_pending, w_pending_nxt;
  logic              r_pend_last, w_pend_last_nxt;
  logic              r_pend_bm, w_pend_bm_nxt;
  beat_t             r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_out_last, w_out_last_nxt;
  logic              r_out_bm, w_out_bm_nxt;
  logic              r_alive;

  beat_t w_beat;
  logic  w_accept, w_drain, w_complete, w_partial;

  assign o_s_ready  = r_alive & ~r_pending;
  assign w_accept   = i_s_valid & o_s_ready;
  assign w_drain    = r_out_valid & i_m_ready;
  assign w_complete = (r_lane == LastLane) | i_s_last;
  assign w_partial  = i_s_last & (r_lane != LastLane);

  // Lanes above the current one are already zero because acc is cleared on every beat hand-off.
  always_comb begin
    w_beat         = r_acc;
    w_beat[r_lane] = i_s_data;
  end

  always_comb begin
    w_acc_nxt       = r_acc;
    w_lane_nxt      = r_lane;
    w_pending_nxt   = r_pending;
    w_pend_last_nxt = r_pend_last;
    w_pend_bm_nxt   = r_pend_bm;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid & ~i_m_ready;
    w_out_last_nxt  = r_out_last;
    w_out_bm_nxt    = r_out_bm;
    if (r_pending) begin
      if (w_drain) begin
        w_out_data_nxt  = r_acc;
        w_out_valid_nxt = 1'b1;
        w_out_last_nxt  = r_pend_last;
        w_out_bm_nxt    = r_pend_bm;
        w_acc_nxt       = '0;
        w_pending_nxt   = 1'b0;
      end
    end else if (w_accept) begin
      if (w_complete) begin
        w_lane_nxt = '0;
        if (!r_out_valid || w_drain) begin
          w_out_data_nxt  = w_beat;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = i_s_last;
          w_out_bm_nxt    = w_partial;
          w_acc_nxt       = '0;
        end else begin
          w_acc_nxt       = w_beat;
          w_pending_nxt   = 1'b1;
          w_pend_last_nxt = i_s_last;
          w_pend_bm_nxt   = w_partial;
        end
      end else begin
        w_acc_nxt  = w_beat;
        w_lane_nxt = r_lane + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc       <= '0;
      r_lane      <= '0;
      r_pending   <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_bm   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_bm    <= 1'b0;
      r_alive     <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_lane      <= w_lane_nxt;
      r_pending   <= w_pending_nxt;
      r_pend_last <= w_pend_last_nxt;
      r_pend_bm   <= w_pend_bm_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_bm    <= w_out_bm_nxt;
      r_alive     <= 1'b1;
    end
  end

  assign o_m_data     = r_out_data;
  assign o_m_valid    = r_out_valid;
  assign o_m_last     = r_out_last;
  assign o_m_bytemask = r_out_bm;
  assign o_busy       = r_out_valid | r_pending | (r_lane != '0);

endmodule

// File: tb/tb_csr_stream_packer.sv
// Directed and randomized bench for csr_stream_packer with a list-based beat reference model.
module tb_csr_stream_packer;

  localparam int unsigned DW = 32;
  localparam int unsigned P  = 4;

  typedef struct {
    logic [P*DW-1:0] data;
    logic            last;
    logic            bm;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [DW-1:0]          s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   s_last;
  logic [P-1:0][DW-1:0]   m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;
  logic                   m_bytemask;
  logic                   busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DW-1:0] cur_q[$];
  beat_t         exp_q[$];
  logic          prev_stall;
  logic [P*DW-1:0] prev_data;
  logic          prev_last, prev_bm;

  csr_stream_packer #(.DATA_WIDTH(DW), .PARALLELISM(P)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_s_data     (s_data),
    .i_s_valid    (s_valid),
    .o_s_ready    (s_ready),
    .i_s_last     (s_last),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_last     (m_last),
    .o_m_bytemask (m_bytemask),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [P*DW-1:0] obs, input logic [P*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: group accepted elements into beats of P, closing early on s_last.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_data", m_data, prev_data);
        chk("stall_last", {m_last, m_bytemask}, {prev_last, prev_bm});
      end
      if (s_valid && s_ready) begin
        cur_q.push_back(s_data);
        if (cur_q.size() == P || s_last) begin
          beat_t b;
          b.data = '0;
          foreach (cur_q[i]) b.data[i*DW +: DW] = cur_q[i];
          b.last = s_last;
          b.bm   = s_last && (cur_q.size() < P);
          exp_q.push_back(b);
          cur_q.delete();
        end
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last_bm", {m_last, m_bytemask}, {e.last, e.bm});
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_bm    = m_bytemask;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    int unsigned t = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned t = 0;
    while ((busy || exp_q.size() != 0) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drained_queue", exp_q.size(), 0);
    chk("drained_busy", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_outputs", {m_valid, m_last, m_bytemask, busy}, 0);
    chk("rst_m_data", m_data, 0);
    cur_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_ready", s_ready, 1);
  endtask

  initial begin
    int unsigned acc;
    int unsigned sent;
    bit done;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: two full beats back to back
    for (int k = 1; k <= 8; k++) begin
      send(DW'(k), k == 8);
      chk("t1_s_ready", s_ready, 1);
      if (k == 4) begin
        chk("t1_beat0_valid", m_valid, 1);
        chk("t1_beat0_data", m_data, {32'd4, 32'd3, 32'd2, 32'd1});
      end
    end
    chk("t1_beat1_valid", m_valid, 1);
    chk("t1_beat1_data", m_data, {32'd8, 32'd7, 32'd6, 32'd5});
    chk("t1_beat1_flags", {m_last, m_bytemask}, 2'b10);
    wait_idle();

    // 2: partial final beat
    for (int k = 1; k <= 6; k++) send(DW'(k), k == 6);
    chk("t2_data", m_data, {32'd0, 32'd0, 32'd6, 32'd5});
    chk("t2_flags", {m_valid, m_last, m_bytemask}, 3'b111);
    wait_idle();

    // 3: single-element packet
    send(32'hA5, 1'b1);
    chk("t3_data", m_data, {32'd0, 32'd0, 32'd0, 32'hA5});
    chk("t3_flags", {m_valid, m_last, m_bytemask}, 3'b111);
    @(posedge clk);
    #1;
    chk("t3_busy_after", {busy, m_valid}, 2'b00);

    // 4: backpressure fills both beat slots
    m_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      s_data  = DW'(acc + 1);
      s_valid = 1'b1;
      s_last  = 1'b0;
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    chk("t4_accepted", acc, 8);
    chk("t4_s_ready", s_ready, 0);
    chk("t4_held", m_data, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("t4_busy", {m_valid, busy}, 2'b11);
    m_ready = 1'b1;
    for (int k = 9; k <= 12; k++) send(DW'(k), k == 12);
    wait_idle();

    // 5: reset mid-packet discards partial lanes
    for (int k = 1; k <= 3; k++) send(DW'(k), 1'b0);
    chk("t5_busy_mid", busy, 1);
    do_reset();
    chk("t5_idle", busy, 0);
    for (int k = 20; k <= 23; k++) send(DW'(k), k == 23);
    chk("t5_data", m_data, {32'd23, 32'd22, 32'd21, 32'd20});
    chk("t5_flags", {m_valid, m_last, m_bytemask}, 3'b110);
    wait_idle();

    // 6: random traffic against the reference model
    done = 1'b0;
    sent = 0;
    fork
      begin
        while (sent < 1000) begin
          int unsigned gap;
          gap = $urandom_range(0, 3);
          if (gap > 1) begin
            repeat (gap - 1) begin
              @(posedge clk);
              #1;
            end
          end
          send($urandom, ($urandom_range(0, 5) == 0) || (sent == 999));
          sent++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    wait_idle();
    chk("t6_no_residue", cur_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
